// File: rtl/data_mem_responder_pkg.sv
// Package: mem_pkg
// Shared types and helpers for the multi-cycle data memory responder.
//  memctrl_e     : access type in RISC-V funct3 encoding
//  state_e       : responder FSM states
//  is_misaligned : size/alignment check on the low address bits
//  is_illegal    : encodings with no defined access (incl. unsigned stores)
package mem_pkg;

  typedef enum logic [2:0] {
    MC_B  = 3'b000,
    MC_H  = 3'b001,
    MC_W  = 3'b010,
    MC_BU = 3'b100,
    MC_HU = 3'b101
  } memctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] memctrl, input logic [1:0] lo);
    case (memctrl)
      MC_H, MC_HU: return lo[0];
      MC_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] memctrl, input logic we);
    case (memctrl)
      MC_B, MC_H, MC_W: return 1'b0;
      MC_BU, MC_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// Module: load_store_align (combinational)
// Lane steering between a 32-bit memory word and the pipeline's right-aligned data.
//  memctrl  in  3   access type (funct3)
//  lane     in  2   addr[1:0] of the access
//  rword    in  32  word read from the array
//  wdata    in  32  right-aligned store data
//  rdata    out 32  extracted and sign/zero-extended load data
//  be       out 4   byte enables for a store (0 for non-store encodings)
//  wword    out 32  store data replicated across lanes; be selects the live bytes
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  memctrl,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wword
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    rdata = '0;
    case (memctrl)
      MC_B:    rdata = {{24{rbyte[7]}}, rbyte};
      MC_BU:   rdata = {24'h000000, rbyte};
      MC_H:    rdata = {{16{rhalf[15]}}, rhalf};
      MC_HU:   rdata = {16'h0000, rhalf};
      MC_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    be    = '0;
    wword = '0;
    case (memctrl)
      MC_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      MC_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      MC_W: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = '0;
        wword = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Module: data_mem_responder
// Multi-cycle load/store responder at the far end of the M-stage memory interface.
// One request in flight; response is a one-cycle resp_valid pulse LATENCY cycles
// after the accept cycle. Array is 2**MEM_ADDR_WIDTH bytes, little-endian, not reset.
//  clk, rst     in   clock; synchronous active-high reset
//  req_valid    in   request present            req_ready  out  accepting (IDLE)
//  req_we       in   1 = store                  req_memctrl in  funct3 access type
//  req_addr     in   byte address (wraps)       req_wdata  in   right-aligned store data
//  resp_valid   out  access complete pulse      resp_rdata out  extended load data / 0
//  resp_err     out  misaligned or illegal      stall      out  hold the pipeline
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_memctrl,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  localparam int unsigned WORDS    = 2 ** (MEM_ADDR_WIDTH - 2);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  state_e state, state_next;
  logic [3:0] cnt;

  logic                      cap_we;
  logic [2:0]                cap_mc;
  logic [MEM_ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]     cap_wdata;

  logic                      acc_we;
  logic [2:0]                acc_mc;
  logic [MEM_ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]     acc_wdata;
  logic [MEM_ADDR_WIDTH-3:0] acc_idx;

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] lsa_rdata;
  logic [DATA_WIDTH-1:0] lsa_wword;
  logic [3:0]            lsa_be;
  logic [3:0]            wr_be;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH];

  assign accept     = (state == IDLE) && req_valid;
  assign req_ready  = (state == IDLE);
  // rst during RESP suppresses the response pulse
  assign resp_valid = (state == RESP) && !rst;
  assign stall      = accept || (state == WAIT);

  // The access happens on the edge entering RESP. From IDLE (LATENCY == 1)
  // that edge is also the capture edge, so the live request is used there.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_mc    = req_memctrl;
      acc_addr  = req_addr[MEM_ADDR_WIDTH-1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_mc    = cap_mc;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  assign acc_idx = acc_addr[MEM_ADDR_WIDTH-1:2];
  assign rd_word = mem[acc_idx];
  assign acc_err = is_misaligned(acc_mc, acc_addr[1:0]) || is_illegal(acc_mc, acc_we);

  load_store_align u_align (
    .memctrl (acc_mc),
    .lane    (acc_addr[1:0]),
    .rword   (rd_word),
    .wdata   (acc_wdata),
    .rdata   (lsa_rdata),
    .be      (lsa_be),
    .wword   (lsa_wword)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) state_next = IDLE;
  end

  assign enter_resp = (state_next == RESP);
  assign wr_be      = (enter_resp && acc_we && !acc_err) ? lsa_be : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      resp_rdata <= (enter_resp && !acc_we && !acc_err) ? lsa_rdata : '0;
      resp_err   <= enter_resp && acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_mc    <= req_memctrl;
      cap_addr  <= req_addr[MEM_ADDR_WIDTH-1:0];
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[acc_idx][8*i +: 8] <= lsa_wword[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed cases plus randomized traffic checked
// against a byte-array reference model. A second instance built with LATENCY=1
// covers the single-cycle path.
module tb_data_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_memctrl;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        l1_req_valid, l1_req_we;
  logic [2:0]  l1_req_memctrl;
  logic [31:0] l1_req_addr, l1_req_wdata;
  logic        l1_req_ready, l1_resp_valid, l1_resp_err, l1_stall;
  logic [31:0] l1_resp_rdata;

  int checks = 0;
  int errors = 0;

  byte unsigned ref_mem [4096];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_memctrl(req_memctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall)
  );

  data_mem_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(12), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
    .req_memctrl(l1_req_memctrl), .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err),
    .stall(l1_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: size/sign from funct3, alignment by modulo, bytes assembled arithmetically.
  function automatic void model(input bit we, input bit [2:0] mc, input bit [31:0] addr,
                                input bit [31:0] wdata, output bit [31:0] rd, output bit err);
    int unsigned size;
    bit sgn;
    int unsigned a;
    longint unsigned v;
    rd = 0; err = 0; sgn = 0; size = 0;
    case (mc)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = we ? 0 : 1;
      3'd5: size = we ? 0 : 2;
      default: size = 0;
    endcase
    a = addr % 4096;
    if (size == 0 || (a % size) != 0) begin
      err = 1;
      return;
    end
    if (we) begin
      for (int unsigned i = 0; i < size; i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int unsigned i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
      if (sgn && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      rd = 32'(v);
    end
  endfunction

  task automatic wait_resp(input string tag, input bit [31:0] erd, input bit eerr,
                           output bit [31:0] rd, output bit er);
    int lat = 0;
    rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
      check_eq({tag, ".wait_stall"}, 32'(stall), 32'd1);
    end
    check_eq({tag, ".latency"}, lat, LAT);
    if (lat != 0) begin
      rd = resp_rdata;
      er = resp_err;
      check_eq({tag, ".rdata"}, resp_rdata, erd);
      check_eq({tag, ".err"}, 32'(resp_err), 32'(eerr));
      check_eq({tag, ".resp_stall"}, 32'(stall), 32'd0);
      check_eq({tag, ".resp_ready"}, 32'(req_ready), 32'd0);
    end
  endtask

  task automatic do_req(input string tag, input bit we, input bit [2:0] mc, input bit [31:0] addr,
                        input bit [31:0] wdata, output bit [31:0] rd, output bit er);
    bit [31:0] erd;
    bit eerr;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_memctrl = mc; req_addr = addr; req_wdata = wdata;
    #1;
    check_eq({tag, ".acc_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, ".acc_stall"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_memctrl = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    model(we, mc, addr, wdata, erd, eerr);
    wait_resp(tag, erd, eerr, rd, er);
  endtask

  task automatic l1_req(input string tag, input bit we, input bit [2:0] mc, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit [31:0] erd, input bit eerr);
    @(negedge clk);
    l1_req_valid = 1'b1; l1_req_we = we; l1_req_memctrl = mc;
    l1_req_addr = addr; l1_req_wdata = wdata;
    @(posedge clk);
    #1;
    l1_req_valid = 1'b0;
    l1_req_addr = $urandom;
    @(negedge clk);
    check_eq({tag, ".valid"}, 32'(l1_resp_valid), 32'd1);
    check_eq({tag, ".rdata"}, l1_resp_rdata, erd);
    check_eq({tag, ".err"}, 32'(l1_resp_err), 32'(eerr));
    @(negedge clk);
    check_eq({tag, ".pulse_end"}, 32'(l1_resp_valid), 32'd0);
  endtask

  initial begin
    bit [31:0] rd, erd, hi;
    bit er, eerr;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_memctrl = 3'd0; req_addr = '0; req_wdata = '0;
    l1_req_valid = 1'b0; l1_req_we = 1'b0; l1_req_memctrl = 3'd0; l1_req_addr = '0; l1_req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.ready", 32'(req_ready), 32'd1);
    check_eq("reset.valid", 32'(resp_valid), 32'd0);
    check_eq("reset.stall", 32'(stall), 32'd0);
    check_eq("reset.rdata", resp_rdata, 32'd0);
    check_eq("reset.err", 32'(resp_err), 32'd0);
    rst = 1'b0;

    // Fill the 256-byte test window so every load there has a known value.
    for (int w = 0; w < 64; w++) do_req("init", 1'b1, 3'd2, 32'(w * 4), $urandom, rd, er);

    do_req("sw_dead", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
    do_req("lw_dead", 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check_eq("lw_dead.const", rd, 32'hDEADBEEF);

    do_req("sw_ext", 1'b1, 3'd2, 32'h20, 32'h80F07F01, rd, er);
    do_req("lb", 1'b0, 3'd0, 32'h23, 32'h0, rd, er);
    check_eq("lb.const", rd, 32'hFFFFFF80);
    do_req("lbu", 1'b0, 3'd4, 32'h23, 32'h0, rd, er);
    check_eq("lbu.const", rd, 32'h00000080);
    do_req("lh", 1'b0, 3'd1, 32'h22, 32'h0, rd, er);
    check_eq("lh.const", rd, 32'hFFFF80F0);
    do_req("lhu", 1'b0, 3'd5, 32'h20, 32'h0, rd, er);
    check_eq("lhu.const", rd, 32'h00007F01);

    do_req("sw_zero", 1'b1, 3'd2, 32'h20, 32'h0, rd, er);
    do_req("sb", 1'b1, 3'd0, 32'h21, 32'hFFFFFFAA, rd, er);
    do_req("lw_sb", 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check_eq("lw_sb.const", rd, 32'h0000AA00);
    do_req("sh", 1'b1, 3'd1, 32'h22, 32'h00001234, rd, er);
    do_req("lw_sh", 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check_eq("lw_sh.const", rd, 32'h1234AA00);

    do_req("lw_mis", 1'b0, 3'd2, 32'h22, 32'h0, rd, er);
    check_eq("lw_mis.const_err", 32'(er), 32'd1);
    do_req("sh_mis", 1'b1, 3'd1, 32'h21, 32'h0000BEEF, rd, er);
    check_eq("sh_mis.const_err", 32'(er), 32'd1);
    do_req("lw_after_mis", 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check_eq("lw_after_mis.const", rd, 32'h1234AA00);
    do_req("mc111", 1'b0, 3'd7, 32'h20, 32'h0, rd, er);
    check_eq("mc111.const_err", 32'(er), 32'd1);
    do_req("sbu_illegal", 1'b1, 3'd4, 32'h20, 32'h000000FF, rd, er);
    do_req("lw_after_sbu", 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check_eq("lw_after_sbu.const", rd, 32'h1234AA00);

    do_req("sw_wrap", 1'b1, 3'd2, 32'hABCD_E024, 32'h0BADCAFE, rd, er);
    do_req("lw_wrap", 1'b0, 3'd2, 32'h0000_0024, 32'h0, rd, er);
    check_eq("lw_wrap.const", rd, 32'h0BADCAFE);

    // rst in the WAIT cycle: store dropped, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memctrl = 3'd2; req_addr = 32'h30; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("rst_wait.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_wait.idle_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_wait.no_resp", 32'(resp_valid), 32'd0);
    end
    do_req("lw_rst_wait", 1'b0, 3'd2, 32'h30, 32'h0, rd, er);

    // rst in the RESP cycle: store already committed, pulse suppressed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memctrl = 3'd2; req_addr = 32'h34; req_wdata = 32'hA5A55A5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(1'b1, 3'd2, 32'h34, 32'hA5A55A5A, erd, eerr);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("rst_resp.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_resp.idle_ready", 32'(req_ready), 32'd1);
    do_req("lw_rst_resp", 1'b0, 3'd2, 32'h34, 32'h0, rd, er);
    check_eq("lw_rst_resp.const", rd, 32'hA5A55A5A);

    // req_valid held high: second request only after RESP; mid-access field changes ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_memctrl = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    req_we = 1'b1; req_memctrl = 3'd2; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    wait_resp("b2b_first", erd, eerr, rd, er);
    check_eq("b2b_first.const", rd, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("b2b.second_ready", 32'(req_ready), 32'd1);
    check_eq("b2b.second_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(1'b1, 3'd2, 32'h14, 32'hCAFEF00D, erd, eerr);
    wait_resp("b2b_second", erd, eerr, rd, er);
    do_req("lw_b2b", 1'b0, 3'd2, 32'h14, 32'h0, rd, er);
    check_eq("lw_b2b.const", rd, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      hi = $urandom;
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {hi[31:12], 4'h0, 8'($urandom_range(0, 255))}, $urandom, rd, er);
    end

    l1_req("l1_sw", 1'b1, 3'd2, 32'h40, 32'h12345678, 32'h0, 1'b0);
    l1_req("l1_lw", 1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 1'b0);
    l1_req("l1_lb", 1'b0, 3'd0, 32'h43, 32'h0, 32'h00000012, 1'b0);
    l1_req("l1_lhu", 1'b0, 3'd5, 32'h40, 32'h0, 32'h00005678, 1'b0);
    l1_req("l1_lh_mis", 1'b0, 3'd1, 32'h41, 32'h0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
